// File: rtl/vrf_banked_mport_if.sv
// Operand-read, response and write-port bundle of the banked vector register file.
// The master side is the dispatch/writeback logic, the slave side is the register file.
interface vrf_banked_mport_if #(
    parameter int NUM_RS = 5,
    parameter int NUM_WR = 2,
    parameter int DATA_W = 128,
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 7
);
    logic                       flush;
    logic                       req_vld;
    logic                       req_ready;
    logic [NUM_RS-1:0]          req_mask;
    logic [NUM_RS*ADDR_W-1:0]   req_addr;
    logic [TAG_W-1:0]           req_tag;
    logic [NUM_RS-1:0]          rsp_vld;
    logic [NUM_RS*DATA_W-1:0]   rsp_data;
    logic [TAG_W-1:0]           rsp_tag;
    logic                       rsp_last;
    logic [NUM_WR-1:0]          wr_vld;
    logic [NUM_WR-1:0]          wr_ready;
    logic [NUM_WR*ADDR_W-1:0]   wr_addr;
    logic [NUM_WR*DATA_W-1:0]   wr_data;

    modport master (
        output flush, req_vld, req_mask, req_addr, req_tag, wr_vld, wr_addr, wr_data,
        input  req_ready, rsp_vld, rsp_data, rsp_tag, rsp_last, wr_ready
    );

    modport slave (
        input  flush, req_vld, req_mask, req_addr, req_tag, wr_vld, wr_addr, wr_data,
        output req_ready, rsp_vld, rsp_data, rsp_tag, rsp_last, wr_ready
    );
endinterface

// File: rtl/vrf_banked_mport.sv
// Banked vector register file: segments striped over single-write banks, multi-operand reads
// serialised over bank read-port conflicts, per-bank write arbitration and write-to-read bypass.
module vrf_banked_mport #(
    parameter int NUM_BANKS   = 4,
    parameter int BANK_RPORTS = 2,
    parameter int NUM_RS      = 5,
    parameter int NUM_WR      = 2,
    parameter int VREG_NUM    = 32,
    parameter int SEGS        = 4,
    parameter int DATA_W      = 128,
    parameter int TAG_W       = 4,
    parameter int ADDR_W      = $clog2(VREG_NUM*SEGS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    vrf_banked_mport_if.slave      bus
);
    localparam int ROWS   = VREG_NUM*SEGS/NUM_BANKS;
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_W - BANK_W;
    localparam logic [7:0] RPORTS = 8'(BANK_RPORTS);

    typedef enum logic [0:0] {IDLE = 1'b0, ARB = 1'b1} state_t;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
        return a[BANK_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:BANK_W];
    endfunction

    state_t                     state_r;
    logic                       ready_r;
    logic [NUM_RS-1:0]          pending_r;
    logic [NUM_RS*ADDR_W-1:0]   addr_r;
    logic [TAG_W-1:0]           tag_r;
    logic [NUM_RS-1:0]          rsp_vld_r;
    logic [NUM_RS*DATA_W-1:0]   rsp_data_r;
    logic [TAG_W-1:0]           rsp_tag_r;
    logic                       rsp_last_r;

    logic [NUM_RS-1:0]          grant_s;
    logic [NUM_RS-1:0]          pend_nxt_s;
    logic [7:0]                 cnt_s;
    logic [NUM_WR-1:0]          wr_ready_s;
    logic [DATA_W-1:0]          rd_s [NUM_RS];
    logic [DATA_W-1:0]          mem_r [NUM_BANKS][ROWS];

    // Write arbitration: lowest-index valid port wins each bank; nothing is accepted in reset
    always_comb begin
        wr_ready_s = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (rstn && bus.wr_vld[i]) begin
                wr_ready_s[i] = 1'b1;
                for (int j = 0; j < i; j++) begin
                    if (bus.wr_vld[j] &&
                        bank_of(bus.wr_addr[j*ADDR_W +: ADDR_W]) == bank_of(bus.wr_addr[i*ADDR_W +: ADDR_W]))
                        wr_ready_s[i] = 1'b0;
                    else
                        wr_ready_s[i] = wr_ready_s[i];
                end
            end else begin
                wr_ready_s[i] = 1'b0;
            end
        end
    end

    // Read grant: a slot wins if fewer than BANK_RPORTS lower pending slots share its bank
    always_comb begin
        grant_s = '0;
        cnt_s   = 8'd0;
        for (int s = 0; s < NUM_RS; s++) begin
            cnt_s = 8'd0;
            for (int t = 0; t < s; t++) begin
                if (pending_r[t] &&
                    bank_of(addr_r[t*ADDR_W +: ADDR_W]) == bank_of(addr_r[s*ADDR_W +: ADDR_W]))
                    cnt_s = cnt_s + 8'd1;
                else
                    cnt_s = cnt_s;
            end
            if (state_r == ARB && pending_r[s] && cnt_s < RPORTS)
                grant_s[s] = 1'b1;
            else
                grant_s[s] = 1'b0;
        end
        pend_nxt_s = pending_r & ~grant_s;
    end

    // Per-slot read data, overridden by a write accepted to the same address this cycle
    always_comb begin
        for (int s = 0; s < NUM_RS; s++) begin
            rd_s[s] = mem_r[bank_of(addr_r[s*ADDR_W +: ADDR_W])][row_of(addr_r[s*ADDR_W +: ADDR_W])];
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_ready_s[i] && bus.wr_addr[i*ADDR_W +: ADDR_W] == addr_r[s*ADDR_W +: ADDR_W])
                    rd_s[s] = bus.wr_data[i*DATA_W +: DATA_W];
                else
                    rd_s[s] = rd_s[s];
            end
        end
    end

    // Storage update; deliberately not reset so contents survive rstn
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_ready_s[i])
                mem_r[bank_of(bus.wr_addr[i*ADDR_W +: ADDR_W])][row_of(bus.wr_addr[i*ADDR_W +: ADDR_W])]
                    <= bus.wr_data[i*DATA_W +: DATA_W];
        end
    end

    // Request FSM with registered ready and response outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= IDLE;
            ready_r    <= 1'b1;
            pending_r  <= '0;
            addr_r     <= '0;
            tag_r      <= '0;
            rsp_vld_r  <= '0;
            rsp_data_r <= '0;
            rsp_tag_r  <= '0;
            rsp_last_r <= 1'b0;
        end else if (bus.flush) begin
            state_r    <= IDLE;
            ready_r    <= 1'b1;
            pending_r  <= '0;
            rsp_vld_r  <= '0;
            rsp_data_r <= '0;
            rsp_last_r <= 1'b0;
        end else begin
            rsp_vld_r <= grant_s;
            for (int s = 0; s < NUM_RS; s++)
                rsp_data_r[s*DATA_W +: DATA_W] <= grant_s[s] ? rd_s[s] : '0;
            case (state_r)
                IDLE: begin
                    rsp_last_r <= 1'b0;
                    if (bus.req_vld && (bus.req_mask != '0)) begin
                        state_r   <= ARB;
                        ready_r   <= 1'b0;
                        pending_r <= bus.req_mask;
                        addr_r    <= bus.req_addr;
                        tag_r     <= bus.req_tag;
                    end
                end
                ARB: begin
                    rsp_tag_r  <= tag_r;
                    rsp_last_r <= (pend_nxt_s == '0);
                    pending_r  <= pend_nxt_s;
                    if (pend_nxt_s == '0) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    ready_r    <= 1'b1;
                    pending_r  <= '0;
                    rsp_last_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.rsp_vld   = rsp_vld_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_tag   = rsp_tag_r;
    assign bus.rsp_last  = rsp_last_r;
    assign bus.wr_ready  = wr_ready_s;
endmodule

// File: tb/tb_vrf_banked_mport.sv
// Directed bench for vrf_banked_mport at default parameters (addr = vreg*4 + seg, bank = seg).
module tb_vrf_banked_mport;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    vrf_banked_mport_if bus_i ();

    vrf_banked_mport dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] slot(input int s);
        return bus_i.rsp_data[s*128 +: 128];
    endfunction

    task automatic wr(input int p, input logic [6:0] a, input logic [127:0] d);
        bus_i.wr_vld[p] = 1'b1;
        bus_i.wr_addr[p*7 +: 7] = a;
        bus_i.wr_data[p*128 +: 128] = d;
    endtask

    task automatic wr_one(input logic [6:0] a, input logic [127:0] d);
        wr(0, a, d);
        tick();
        bus_i.wr_vld = 2'b00;
    endtask

    // Presents a request for one cycle; returns in the first ARB cycle
    task automatic req(input logic [4:0] m, input logic [6:0] a0, input logic [6:0] a1,
                       input logic [6:0] a2, input logic [6:0] a3, input logic [6:0] a4,
                       input logic [3:0] t);
        bus_i.req_vld  = 1'b1;
        bus_i.req_mask = m;
        bus_i.req_addr = {a4, a3, a2, a1, a0};
        bus_i.req_tag  = t;
        tick();
        bus_i.req_vld  = 1'b0;
    endtask

    initial begin
        bus_i.flush    = 1'b0;
        bus_i.req_vld  = 1'b0;
        bus_i.req_mask = 5'b00000;
        bus_i.req_addr = 35'd0;
        bus_i.req_tag  = 4'd0;
        bus_i.wr_vld   = 2'b00;
        bus_i.wr_addr  = 14'd0;
        bus_i.wr_data  = 256'd0;

        // Reset values and wr_ready gating
        tick();
        tick();
        wr(0, 7'd0, 128'h0);
        #1;
        chk("rst_wr_ready_gated", 128'(bus_i.wr_ready), 128'(2'b00));
        chk("rst_req_ready", 128'(bus_i.req_ready), 128'(1'b1));
        chk("rst_rsp_vld", 128'(bus_i.rsp_vld), 128'(5'b00000));
        chk("rst_rsp_last", 128'(bus_i.rsp_last), 128'(1'b0));
        chk("rst_rsp_tag", 128'(bus_i.rsp_tag), 128'(4'd0));
        chk("rst_rsp_data_lo", bus_i.rsp_data[127:0], 128'h0);
        rstn = 1'b1;
        #1;
        chk("wr_ready_after_rst", 128'(bus_i.wr_ready), 128'(2'b01));
        bus_i.wr_vld = 2'b00;
        tick();

        // 1. Conflict-free read
        wr(0, 7'd4, 128'hA0);
        wr(1, 7'd5, 128'hA1);
        #1;
        chk("wr_two_banks_ready", 128'(bus_i.wr_ready), 128'(2'b11));
        tick();
        wr(0, 7'd6, 128'hA2);
        wr(1, 7'd7, 128'hA3);
        tick();
        bus_i.wr_vld = 2'b00;
        req(5'b01111, 7'd4, 7'd5, 7'd6, 7'd7, 7'd0, 4'd3);
        chk("t1_ready_low_in_arb", 128'(bus_i.req_ready), 128'(1'b0));
        chk("t1_no_rsp_yet", 128'(bus_i.rsp_vld), 128'(5'b00000));
        tick();
        chk("t1_vld", 128'(bus_i.rsp_vld), 128'(5'b01111));
        chk("t1_d0", slot(0), 128'hA0);
        chk("t1_d1", slot(1), 128'hA1);
        chk("t1_d2", slot(2), 128'hA2);
        chk("t1_d3", slot(3), 128'hA3);
        chk("t1_d4_zero", slot(4), 128'h0);
        chk("t1_tag", 128'(bus_i.rsp_tag), 128'(4'd3));
        chk("t1_last", 128'(bus_i.rsp_last), 128'(1'b1));
        chk("t1_ready_back", 128'(bus_i.req_ready), 128'(1'b1));
        tick();
        chk("t1_vld_clear", 128'(bus_i.rsp_vld), 128'(5'b00000));
        chk("t1_last_clear", 128'(bus_i.rsp_last), 128'(1'b0));

        // 2. Bank conflict over three beats
        wr_one(7'd0, 128'hB0);
        wr_one(7'd8, 128'hB2);
        wr_one(7'd12, 128'hB3);
        wr_one(7'd16, 128'hB4);
        req(5'b11111, 7'd0, 7'd4, 7'd8, 7'd12, 7'd16, 4'd5);
        tick();
        chk("t2_b1_vld", 128'(bus_i.rsp_vld), 128'(5'b00011));
        chk("t2_b1_d0", slot(0), 128'hB0);
        chk("t2_b1_d1", slot(1), 128'hA0);
        chk("t2_b1_last", 128'(bus_i.rsp_last), 128'(1'b0));
        chk("t2_b1_tag", 128'(bus_i.rsp_tag), 128'(4'd5));
        chk("t2_b1_ready", 128'(bus_i.req_ready), 128'(1'b0));
        tick();
        chk("t2_b2_vld", 128'(bus_i.rsp_vld), 128'(5'b01100));
        chk("t2_b2_d2", slot(2), 128'hB2);
        chk("t2_b2_d3", slot(3), 128'hB3);
        chk("t2_b2_d0_zero", slot(0), 128'h0);
        chk("t2_b2_last", 128'(bus_i.rsp_last), 128'(1'b0));
        tick();
        chk("t2_b3_vld", 128'(bus_i.rsp_vld), 128'(5'b10000));
        chk("t2_b3_d4", slot(4), 128'hB4);
        chk("t2_b3_last", 128'(bus_i.rsp_last), 128'(1'b1));
        chk("t2_b3_ready", 128'(bus_i.req_ready), 128'(1'b1));

        // 3. Write conflict in bank 2, retry of port 1
        wr(0, 7'd2, 128'hC0);
        wr(1, 7'd6, 128'hC1);
        #1;
        chk("t3_wr_conflict", 128'(bus_i.wr_ready), 128'(2'b01));
        tick();
        bus_i.wr_vld = 2'b10;
        #1;
        chk("t3_wr_retry", 128'(bus_i.wr_ready), 128'(2'b10));
        tick();
        bus_i.wr_vld = 2'b00;
        req(5'b00011, 7'd2, 7'd6, 7'd0, 7'd0, 7'd0, 4'd1);
        tick();
        chk("t3_vld", 128'(bus_i.rsp_vld), 128'(5'b00011));
        chk("t3_d0", slot(0), 128'hC0);
        chk("t3_d1", slot(1), 128'hC1);
        chk("t3_last", 128'(bus_i.rsp_last), 128'(1'b1));

        // 4. Bypass, then a read granted one cycle before the write
        wr_one(7'd9, 128'h11);
        req(5'b00001, 7'd9, 7'd0, 7'd0, 7'd0, 7'd0, 4'd7);
        wr(0, 7'd9, 128'h55);
        tick();
        bus_i.wr_vld = 2'b00;
        chk("t4_bypass_vld", 128'(bus_i.rsp_vld), 128'(5'b00001));
        chk("t4_bypass_data", slot(0), 128'h55);
        wr_one(7'd9, 128'h11);
        req(5'b00001, 7'd9, 7'd0, 7'd0, 7'd0, 7'd0, 4'd7);
        tick();
        wr(0, 7'd9, 128'h55);
        #1;
        chk("t4_old_data", slot(0), 128'h11);
        tick();
        bus_i.wr_vld = 2'b00;
        req(5'b00001, 7'd9, 7'd0, 7'd0, 7'd0, 7'd0, 4'd7);
        tick();
        chk("t4_write_landed", slot(0), 128'h55);

        // 5. Flush after the first beat of a conflict request
        req(5'b11111, 7'd0, 7'd4, 7'd8, 7'd12, 7'd16, 4'd9);
        tick();
        chk("t5_b1_vld", 128'(bus_i.rsp_vld), 128'(5'b00011));
        bus_i.flush = 1'b1;
        tick();
        bus_i.flush = 1'b0;
        chk("t5_flush_vld", 128'(bus_i.rsp_vld), 128'(5'b00000));
        chk("t5_flush_last", 128'(bus_i.rsp_last), 128'(1'b0));
        chk("t5_flush_ready", 128'(bus_i.req_ready), 128'(1'b1));
        tick();
        chk("t5_no_more_beats", 128'(bus_i.rsp_vld), 128'(5'b00000));
        bus_i.flush = 1'b1;
        req(5'b00001, 7'd4, 7'd0, 7'd0, 7'd0, 7'd0, 4'd6);
        bus_i.flush = 1'b0;
        chk("t5_flush_beats_req", 128'(bus_i.req_ready), 128'(1'b1));
        tick();
        chk("t5_flush_beats_req_rsp", 128'(bus_i.rsp_vld), 128'(5'b00000));
        req(5'b00001, 7'd4, 7'd0, 7'd0, 7'd0, 7'd0, 4'd2);
        tick();
        chk("t5_new_vld", 128'(bus_i.rsp_vld), 128'(5'b00001));
        chk("t5_new_data", slot(0), 128'hA0);
        chk("t5_new_tag", 128'(bus_i.rsp_tag), 128'(4'd2));
        chk("t5_new_last", 128'(bus_i.rsp_last), 128'(1'b1));

        // Empty mask is accepted and dropped
        req(5'b00000, 7'd4, 7'd0, 7'd0, 7'd0, 7'd0, 4'd8);
        chk("empty_mask_ready", 128'(bus_i.req_ready), 128'(1'b1));
        tick();
        chk("empty_mask_no_rsp", 128'(bus_i.rsp_vld), 128'(5'b00000));

        // 6. Reset in the middle of ARB
        req(5'b11111, 7'd0, 7'd4, 7'd8, 7'd12, 7'd16, 4'd4);
        tick();
        chk("t6_b1_vld", 128'(bus_i.rsp_vld), 128'(5'b00011));
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("t6_rst_vld", 128'(bus_i.rsp_vld), 128'(5'b00000));
        chk("t6_rst_last", 128'(bus_i.rsp_last), 128'(1'b0));
        chk("t6_rst_ready", 128'(bus_i.req_ready), 128'(1'b1));
        chk("t6_rst_tag", 128'(bus_i.rsp_tag), 128'(4'd0));
        tick();
        chk("t6_no_beats", 128'(bus_i.rsp_vld), 128'(5'b00000));
        req(5'b00111, 7'd2, 7'd6, 7'd16, 7'd0, 7'd0, 4'd10);
        tick();
        chk("t6_vld", 128'(bus_i.rsp_vld), 128'(5'b00111));
        chk("t6_d0", slot(0), 128'hC0);
        chk("t6_d1", slot(1), 128'hC1);
        chk("t6_d2", slot(2), 128'hB4);
        chk("t6_tag", 128'(bus_i.rsp_tag), 128'(4'd10));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
